// File: rtl/dct_row_scheduler.sv
// Row sequencer for the 8x8 DCT: issues each row, waits the engine latency, strobes capture,
// then hands the finished block downstream. Define DCT_2PASS_EN to add a column pass.
module dct_row_scheduler #(
  parameter int ROW_WAIT   = 500,
  parameter int WAIT_W     = 10,
  parameter int ROW_STRIDE = 112,
  parameter int OFS_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  output logic             busy,
  output logic [2:0]       row_sel,
  output logic             row_go,
  output logic             row_capture,
  output logic [OFS_W-1:0] out_offset,
  output logic             pass,
  output logic             blk_valid,
  input  logic             blk_ready
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [2:0]        row_q, row_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic              busy_q, busy_d;
  logic              go_q, go_d;
  logic              cap_q, cap_d;
  logic              valid_q, valid_d;

`ifdef DCT_2PASS_EN
  logic pass_q, pass_d;
  assign pass = pass_q;
`else
  assign pass = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    row_d   = row_q;
    go_d    = 1'b0;
    cap_d   = 1'b0;
    valid_d = valid_q;
`ifdef DCT_2PASS_EN
    pass_d  = pass_q;
`endif
    // Pulses are computed for the state being entered, so they line up with it on the outputs.
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            row_d   = 3'd0;
            state_d = S_ISSUE;
            go_d    = 1'b1;
`ifdef DCT_2PASS_EN
            pass_d  = 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          wait_d  = WAIT_W'(ROW_WAIT - 1);
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            state_d = S_CAPTURE;
            cap_d   = 1'b1;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        S_CAPTURE: begin
          if (row_q != 3'd7) begin
            row_d   = row_q + 3'd1;
            state_d = S_ISSUE;
            go_d    = 1'b1;
          end
`ifdef DCT_2PASS_EN
          else if (!pass_q) begin
            pass_d  = 1'b1;
            row_d   = 3'd0;
            state_d = S_ISSUE;
            go_d    = 1'b1;
          end
`endif
          else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          // First DONE cycle raises blk_valid; the handshake is taken on a later edge.
          if (!valid_q) begin
            valid_d = 1'b1;
          end else if (blk_ready) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    ofs_d  = OFS_W'(row_d) * OFS_W'(ROW_STRIDE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      row_q   <= 3'd0;
      ofs_q   <= '0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
      cap_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      row_q   <= row_d;
      ofs_q   <= ofs_d;
      busy_q  <= busy_d;
      go_q    <= go_d;
      cap_q   <= cap_d;
      valid_q <= valid_d;
    end
  end

`ifdef DCT_2PASS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pass_q <= 1'b0;
    else        pass_q <= pass_d;
  end
`endif

  assign busy        = busy_q;
  assign row_sel     = row_q;
  assign row_go      = go_q;
  assign row_capture = cap_q;
  assign out_offset  = ofs_q;
  assign blk_valid   = valid_q;

endmodule

// File: tb/tb_dct_row_scheduler.sv
// Directed bench for dct_row_scheduler with ROW_WAIT=4: checkpoint table over a recorded
// block trace, plus hand sequences for backpressure, stall and mid-block reset.
module tb_dct_row_scheduler;

  localparam int RW = 4;
`ifdef DCT_2PASS_EN
  localparam int   NROWS = 16;
  localparam logic TWO   = 1'b1;
`else
  localparam int   NROWS = 8;
  localparam logic TWO   = 1'b0;
`endif
  localparam int LAT = NROWS * (RW + 2) + 1;
  localparam int TR  = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       start = 1'b0;
  logic       blk_ready = 1'b1;
  logic       busy, row_go, row_capture, pass, blk_valid;
  logic [2:0] row_sel;
  logic [9:0] out_offset;

  dct_row_scheduler #(.ROW_WAIT(RW), .WAIT_W(10), .ROW_STRIDE(112), .OFS_W(10)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .busy(busy),
    .row_sel(row_sel), .row_go(row_go), .row_capture(row_capture), .out_offset(out_offset),
    .pass(pass), .blk_valid(blk_valid), .blk_ready(blk_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       go;
    logic       cap;
    logic [2:0] sel;
    logic [9:0] ofs;
    logic       vld;
    logic       bsy;
    logic       ps;
  } smp_t;

  typedef struct {
    int   n;
    smp_t e;
  } vec_t;

  vec_t vecs[$];
  smp_t tr[TR];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int n, input logic go, input logic cap, input int sel,
                              input int ofs, input logic vld, input logic bsy, input logic ps);
    vec_t v;
    v.n     = n;
    v.e.go  = go;
    v.e.cap = cap;
    v.e.sel = 3'(sel);
    v.e.ofs = 10'(ofs);
    v.e.vld = vld;
    v.e.bsy = bsy;
    v.e.ps  = ps;
    return v;
  endfunction

  function automatic smp_t grab();
    smp_t s;
    s.go  = row_go;
    s.cap = row_capture;
    s.sel = row_sel;
    s.ofs = out_offset;
    s.vld = blk_valid;
    s.bsy = busy;
    s.ps  = pass;
    return s;
  endfunction

  function automatic string fmt(input smp_t s);
    return $sformatf("go=%b cap=%b sel=%0d ofs=%0d vld=%b busy=%b pass=%b",
                     s.go, s.cap, s.sel, s.ofs, s.vld, s.bsy, s.ps);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic chk_smp(input string name, input smp_t act, input smp_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {%s}, expected {%s}", name, fmt(act), fmt(exp));
    end else begin
      $display("ok   %s {%s}", name, fmt(act));
    end
  endtask

  // Issues one start (called just after a negedge) and records TR cycles from the accept edge.
  task automatic run_block();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < TR; i++) begin
      @(negedge clk);
      tr[i] = grab();
    end
  endtask

  task automatic check_trace(input string tag);
    int ngo, ncap, nvld;
    foreach (vecs[k]) chk_smp($sformatf("%s c%0d", tag, vecs[k].n), tr[vecs[k].n], vecs[k].e);
    ngo = 0; ncap = 0; nvld = 0;
    for (int i = 0; i < TR; i++) begin
      ngo  += int'(tr[i].go);
      ncap += int'(tr[i].cap);
      nvld += int'(tr[i].vld);
    end
    chk({tag, " row_go count"}, ngo, NROWS);
    chk({tag, " row_capture count"}, ncap, NROWS);
    chk({tag, " blk_valid cycles"}, nvld, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int   first_v;
    smp_t zero;
    zero = '0;

    // Checkpoints relative to the start-accept edge (cycle 0 = ISSUE of row 0).
    vecs.push_back(mk(0,  1, 0, 0, 0,   0, 1, 0));
    vecs.push_back(mk(1,  0, 0, 0, 0,   0, 1, 0));
    vecs.push_back(mk(4,  0, 0, 0, 0,   0, 1, 0));
    vecs.push_back(mk(5,  0, 1, 0, 0,   0, 1, 0));
    vecs.push_back(mk(6,  1, 0, 1, 112, 0, 1, 0));
    vecs.push_back(mk(11, 0, 1, 1, 112, 0, 1, 0));
    vecs.push_back(mk(12, 1, 0, 2, 224, 0, 1, 0));
    vecs.push_back(mk(17, 0, 1, 2, 224, 0, 1, 0));
    vecs.push_back(mk(23, 0, 1, 3, 336, 0, 1, 0));
    vecs.push_back(mk(29, 0, 1, 4, 448, 0, 1, 0));
    vecs.push_back(mk(35, 0, 1, 5, 560, 0, 1, 0));
    vecs.push_back(mk(41, 0, 1, 6, 672, 0, 1, 0));
    vecs.push_back(mk(42, 1, 0, 7, 784, 0, 1, 0));
    vecs.push_back(mk(47, 0, 1, 7, 784, 0, 1, 0));
`ifdef DCT_2PASS_EN
    vecs.push_back(mk(48, 1, 0, 0, 0,   0, 1, 1));
    vecs.push_back(mk(53, 0, 1, 0, 0,   0, 1, 1));
    vecs.push_back(mk(95, 0, 1, 7, 784, 0, 1, 1));
`endif
    vecs.push_back(mk(LAT - 1, 0, 0, 7, 784, 0, 1, TWO));
    vecs.push_back(mk(LAT,     0, 0, 7, 784, 1, 1, TWO));
    vecs.push_back(mk(LAT + 1, 0, 0, 7, 784, 0, 0, TWO));
    vecs.push_back(mk(LAT + 5, 0, 0, 7, 784, 0, 0, TWO));

    // Reset then idle.
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_smp("reset state", grab(), zero);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle c%0d busy/go/cap/vld", i), {busy, row_go, row_capture, blk_valid}, 0);
    end

    // Nominal block with blk_ready held high.
    run_block();
    check_trace("nominal");

    // Backpressure: blk_ready low for 10 blk_valid cycles, stray starts ignored.
    blk_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    first_v = -1;
    for (int n = 0; n < 400 && first_v < 0; n++) begin
      @(negedge clk);
      if (blk_valid) first_v = n;
    end
    chk("bp first blk_valid cycle", first_v, LAT);
    for (int i = 1; i < 10; i++) begin
      start = i[0];
      @(negedge clk);
      chk($sformatf("bp hold %0d vld/busy/go", i), {blk_valid, busy, row_go}, 3'b110);
    end
    blk_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("bp accept vld/busy/go", {blk_valid, busy, row_go}, 0);
    start = 1'b0;
    @(negedge clk);
    chk("bp after accept busy/go", {busy, row_go}, 0);
    run_block();
    check_trace("bp-next");

    // Stall: enable low for 7 edges during row 3 WAIT.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    first_v = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n >= 20 && n <= 26)
        chk($sformatf("stall c%0d go/cap/sel", n), {row_go, row_capture, row_sel}, 5'b00011);
      if (n == 30) chk("stall row3 capture cap/sel", {row_capture, row_sel}, 4'b1011);
      if (blk_valid && first_v < 0) first_v = n;
      if (n == 19) enable = 1'b0;
      if (n == 26) enable = 1'b1;
    end
    chk("stall latency", first_v, LAT + 7);

    // Asynchronous reset during CAPTURE of row 5.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n <= 35; n++) @(negedge clk);
    chk("pre-reset row5 cap/sel", {row_capture, row_sel}, 4'b1101);
    #2 reset = 1'b0;
    #1 chk_smp("async reset outputs", grab(), zero);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post-reset idle busy/vld", {busy, blk_valid}, 0);
    run_block();
    check_trace("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dct_row_scheduler.md
Name: dct_row_scheduler

Overview:
- Sequences the 8-row DCT datapath across one 8x8 block of Y/Cr/Cb.
- Drives the row select into the DCT row engines and waits a fixed compute latency per row.
- Strobes capture of each 112-bit row slice at the correct output offset.
- Presents a completed block to downstream zig-zag/entropy coding via a valid/ready handshake.

Parameters:
- ROW_WAIT, 500, cycles between row issue and row capture; legal range 1..(2^WAIT_W - 1).
- WAIT_W, 10, width of the wait counter.
- ROW_STRIDE, 112, bit stride per row in the 896-bit output (8 coefficients x 14 bits).
- OFS_W, 10, width of out_offset.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  global run enable; low freezes all state.
- start  input  1  request to process one block; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- row_sel  output  3  current row index to the DCT row engines.
- row_go  output  1  one-cycle pulse: row_sel is valid, engines begin the row.
- row_capture  output  1  one-cycle pulse: store engine outputs at out_offset.
- out_offset  output  OFS_W  bit offset of the current row slice, row_sel*ROW_STRIDE.
- pass  output  1  0 = row pass, 1 = column pass (DCT_2PASS_EN only, else constant 0).
- blk_valid  output  1  block complete, held until accepted.
- blk_ready  input  1  downstream accepts the block.

Behaviour:
- Reset (reset=0, async): state=IDLE; row_sel=0, out_offset=0, pass=0, wait counter=0; busy, row_go, row_capture and blk_valid all 0. Reset asserted mid-block aborts the block immediately, with no blk_valid.
- All outputs are registered.
- When enable=0: state, counters and row_sel hold; row_go and row_capture are forced 0; blk_valid holds its value. Operation resumes exactly where it stopped.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE: on start=1 and enable=1, set row=0, pass=0, go to ISSUE. start in any other state is ignored and not queued.
- ISSUE (1 cycle): row_go=1; load wait counter with ROW_WAIT-1; go to WAIT.
- WAIT: decrement the counter each enabled cycle. When it is 0, go to CAPTURE. WAIT lasts ROW_WAIT cycles.
- CAPTURE (1 cycle): row_capture=1, out_offset=row*ROW_STRIDE.
  - row<7: row+1, go to ISSUE.
  - row==7: go to DONE.
- DONE: blk_valid=1. When blk_ready=1 at a clock edge, drop blk_valid and return to IDLE the next cycle.
  - blk_ready may already be high when blk_valid rises; the handshake then completes in that first cycle.
  - start in the same cycle as the accepting edge is ignored.
- Row timing: ROW_WAIT+2 cycles per row.
- Block latency: blk_valid first asserts 8*(ROW_WAIT+2)+1 cycles after the edge that accepts start (49 for ROW_WAIT=4).
- out_offset values in order: 0, 112, 224, 336, 448, 560, 672, 784. The maximum, 784, fits in 10 bits.
- row_sel changes only on entry to ISSUE. It is stable from row_go through row_capture.

Optional Feature:
- Macro: DCT_2PASS_EN.
- Defined: after row 7 of pass 0 in CAPTURE, set pass=1 and row=0, and go to ISSUE. Eight column rows then run with identical timing and offsets. DONE is entered only after row 7 of pass 1. Block latency becomes 16*(ROW_WAIT+2)+1.
- Not defined: pass is constant 0, single pass only, and the pass register is not synthesized.

Test Plan:
- Reset then idle: ROW_WAIT=4, reset pulse, start=0 for 20 cycles -> busy=0, blk_valid=0, no row_go or row_capture pulses.
- Nominal block: ROW_WAIT=4, one start pulse, blk_ready=1 -> 8 row_go and 8 row_capture pulses 6 cycles apart. out_offset sequence 0..784 in steps of 112. blk_valid high for exactly 1 cycle, 49 cycles after start. busy=0 on the next cycle.
- Backpressure: blk_ready=0 for 10 cycles after blk_valid -> blk_valid held 10 cycles, start pulses during that time ignored. Raise blk_ready -> IDLE. A new start is then accepted.
- Stall: drop enable for 7 cycles during WAIT of row 3 -> no pulses while stalled, row_sel stays 3. Total latency becomes 56 cycles.
- Async reset mid-block: assert reset during CAPTURE of row 5, off-edge -> all outputs 0 immediately. After release, the next start runs rows 0..7 cleanly.
- DCT_2PASS_EN defined, ROW_WAIT=4 -> 16 row_capture pulses; pass goes 0→1 after the 8th; blk_valid at cycle 97.
